pixel_framebuffer: RTL

- Receiving end of the pixel-write interface (x, y, colour, enable) driven by the pong drawing engine.
- Stores a 64x32, 3-bit-per-pixel frame in on-chip memory.
- Continuously scans the frame out in raster order over a valid/ready stream for the display driver.
- Provides a full-frame clear sequence after reset or on request.

---
 rtl/pixel_framebuffer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_framebuffer.sv
// ---------------------------------------------------------------------------
// pixel_framebuffer
//
// Frame store for the pong display path. The drawing engine writes single
// pixels (x, y, colour, enable); the frame is held in an inferred block RAM
// addressed by {y, x} and is scanned out continuously in raster order over a
// valid/ready stream. After reset, or on a clear request, every pixel is
// overwritten with CLEAR_COLOUR (one pixel per cycle) before scanning resumes.
//
// Ports
//   clk         system clock, everything on the rising edge
//   reset       synchronous, active-high reset
//   x, y        write coordinates
//   colour      write data
//   enable      write strobe, one pixel per cycle
//   clear       single-cycle request to wipe the frame
//   busy        high while the clear sequence runs (writes are dropped)
//   pix_valid   output pixel valid
//   pix_ready   downstream accepts the output pixel
//   pix_x/pix_y coordinates of the output pixel
//   pix_colour  colour of the output pixel
//   pix_sof     output pixel is (0,0)
//   pix_eol     output pixel is the last column of a row
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
// ---------------------------------------------------------------------------
module pixel_framebuffer #(
    parameter int            XW           = 6,
    parameter int            YW           = 5,
    parameter int            CW           = 3,
    parameter logic [CW-1:0] CLEAR_COLOUR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [CW-1:0] colour,
    input  logic          enable,
    input  logic          clear,
    output logic          busy,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [CW-1:0] pix_colour,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          frame_done
);

    localparam int AW    = XW + YW;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        CLEAR = 1'b0,
        SCAN  = 1'b1
    } state_t;

    state_t stateReg, stateNext;

    logic [CW-1:0] frameMem [DEPTH];

    logic [AW-1:0] clearAddrReg;
    logic [XW-1:0] scanXReg;
    logic [YW-1:0] scanYReg;

    // Read stage: RAM output register plus the coordinates it belongs to.
    logic          rdValidReg;
    logic [XW-1:0] rdXReg;
    logic [YW-1:0] rdYReg;
    logic [CW-1:0] rdDataReg;

    logic          memWe;
    logic [AW-1:0] memWAddr;
    logic [CW-1:0] memWData;
    logic [AW-1:0] scanAddr;
    logic          readIssue;
    logic          outAdvance;
    logic          abortScan;

    assign scanAddr   = {scanYReg, scanXReg};
    assign busy       = (stateReg == CLEAR);
    // The output register can take a new pixel this cycle.
    assign outAdvance = !pix_valid || pix_ready;
    assign abortScan  = (stateReg == SCAN) && clear;

    // Next state, write-port mux and read issue.
    // A read is issued whenever the read stage will be empty after this edge:
    // either it holds nothing, or its pixel moves into the output register
    // now. That keeps one pixel per cycle with pix_ready high and makes the
    // first pixel appear two cycles after the scan starts.
    always_comb begin
        stateNext = stateReg;
        memWe     = 1'b0;
        memWAddr  = {y, x};
        memWData  = colour;
        readIssue = 1'b0;
        case (stateReg)
            CLEAR: begin
                memWe    = 1'b1;
                memWAddr = clearAddrReg;
                memWData = CLEAR_COLOUR;
                if (clearAddrReg == '1) begin
                    stateNext = SCAN;
                end
            end
            SCAN: begin
                // A write coinciding with a clear request still lands; the
                // clear sweep overwrites it afterwards.
                memWe = enable;
                if (clear) begin
                    stateNext = CLEAR;
                end else begin
                    readIssue = !rdValidReg || outAdvance;
                end
            end
            default: begin
                stateNext = CLEAR;
            end
        endcase
    end

    // Frame memory: single write port, registered read with write-first
    // bypass so a same-cycle write to the scanned pixel is seen immediately.
    always_ff @(posedge clk) begin
        if (memWe) begin
            frameMem[memWAddr] <= memWData;
        end
        if (readIssue) begin
            if (memWe && (memWAddr == scanAddr)) begin
                rdDataReg <= memWData;
            end else begin
                rdDataReg <= frameMem[scanAddr];
            end
        end
    end

    // Control, scan counter and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= CLEAR;
            clearAddrReg <= '0;
            scanXReg     <= '0;
            scanYReg     <= '0;
            rdValidReg   <= 1'b0;
            rdXReg       <= '0;
            rdYReg       <= '0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_colour   <= '0;
            pix_sof      <= 1'b0;
            pix_eol      <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            frame_done <= pix_valid && pix_ready && (pix_x == '1) && (pix_y == '1);

            // Wraps back to zero on the final clear write, ready for next time.
            if (stateReg == CLEAR) begin
                clearAddrReg <= clearAddrReg + 1'b1;
            end

            if (abortScan) begin
                // Drop everything in flight and restart from the top-left.
                clearAddrReg <= '0;
                scanXReg     <= '0;
                scanYReg     <= '0;
                rdValidReg   <= 1'b0;
                pix_valid    <= 1'b0;
            end else begin
                if (readIssue) begin
                    rdXReg   <= scanXReg;
                    rdYReg   <= scanYReg;
                    scanXReg <= scanXReg + 1'b1;
                    if (scanXReg == '1) begin
                        scanYReg <= scanYReg + 1'b1;
                    end
                end

                rdValidReg <= readIssue || (rdValidReg && !outAdvance);

                // Output only changes when empty or accepted, so it holds
                // steady under backpressure.
                if (outAdvance) begin
                    pix_valid <= rdValidReg;
                    if (rdValidReg) begin
                        pix_x      <= rdXReg;
                        pix_y      <= rdYReg;
                        pix_colour <= rdDataReg;
                        pix_sof    <= (rdXReg == '0) && (rdYReg == '0);
                        pix_eol    <= (rdXReg == '1);
                    end
                end
            end
        end
    end

endmodule
